// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding,
// SRAM bus widths and the default per-half-word wait length.
package mem_pkg;

   // Access sequencer states; values are fixed so debug probes read consistently.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   localparam int SRAM_ADDR_W     = 18;
   localparam int SRAM_DATA_W     = 16;
   localparam int WAIT_CYCLES_DEF = 2;
   localparam int CNT_W           = 3;

   // Last value the wait counter reaches before moving to the next half-word.
   function automatic logic [CNT_W-1:0] last_count(input int wait_cycles);
      return CNT_W'(wait_cycles - 1);
   endfunction

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller. A 32-bit load/store is split into two
// half-word accesses (low half first) on a 16-bit asynchronous SRAM. The
// pipeline is frozen through `ready` until the second half has completed.
// The board-level tristate for the DQ pins is built outside this block
// from SRAM_DQ_out / SRAM_DQ_oe.
module mem_sram_ctrl
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   MEM_R_EN,
   input  logic                   MEM_W_EN,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
   output logic                   SRAM_DQ_oe,
   input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_OE_N
);

   localparam logic [CNT_W-1:0] CNT_LAST = last_count(WAIT_CYCLES);

   mem_state_e              state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic                    is_store_reg;
   logic [16:0]             addr_reg;
   logic [31:0]             wdata_reg;
   logic [31:0]             read_data_reg;

   logic [SRAM_ADDR_W-1:0]  sram_addr_reg, sram_addr_next;
   logic [SRAM_DATA_W-1:0]  dq_out_reg, dq_out_next;
   logic                    dq_oe_reg, dq_oe_next;
   logic                    we_n_reg, we_n_next;
   logic                    oe_n_reg, oe_n_next;

   logic                    req;
   logic                    cnt_last;
   logic                    acc_store;
   logic [16:0]             acc_addr;
   logic [31:0]             acc_wdata;
   logic                    half_next;

   // Only the half-word-aligned word index selects SRAM locations.
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^{address[31:19], address[1:0]};

   assign req      = MEM_R_EN | MEM_W_EN;
   assign cnt_last = (cnt_reg == CNT_LAST);

   // In IDLE the access is being accepted this edge, so the bus setup for
   // the first LOW cycle must come straight from the inputs; afterwards the
   // latched copies are used and input wiggles are ignored.
   always_comb begin
      acc_store = is_store_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
      if (state_reg == ST_IDLE) begin
         acc_store = MEM_W_EN;
         acc_addr  = address[18:2];
         acc_wdata = write_data;
      end
   end

   // Next-state and wait-counter sequencing.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req) begin
               state_next = ST_LOW;
               cnt_next   = '0;
            end
         end
         ST_LOW: begin
            if (cnt_last) begin
               state_next = ST_HIGH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_HIGH: begin
            if (cnt_last) begin
               state_next = ST_DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // SRAM bus values for the upcoming cycle, derived from the next state so
   // the registered strobes line up exactly with the LOW/HIGH cycles.
   always_comb begin
      sram_addr_next = sram_addr_reg;
      dq_out_next    = dq_out_reg;
      dq_oe_next     = 1'b0;
      we_n_next      = 1'b1;
      oe_n_next      = 1'b1;
      half_next      = (state_next == ST_HIGH);
      if ((state_next == ST_LOW) || (state_next == ST_HIGH)) begin
         sram_addr_next = {acc_addr, half_next};
         if (acc_store) begin
            dq_out_next = half_next ? acc_wdata[31:16] : acc_wdata[15:0];
            dq_oe_next  = 1'b1;
            we_n_next   = 1'b0;
         end else begin
            oe_n_next = 1'b0;
         end
      end
   end

   // State, counter and request latches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         is_store_reg <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if ((state_reg == ST_IDLE) && req) begin
            is_store_reg <= MEM_W_EN;
            addr_reg     <= address[18:2];
            wdata_reg    <= write_data;
         end
      end
   end

   // Registered SRAM bus drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_addr_reg <= '0;
         dq_out_reg    <= '0;
         dq_oe_reg     <= 1'b0;
         we_n_reg      <= 1'b1;
         oe_n_reg      <= 1'b1;
      end else begin
         sram_addr_reg <= sram_addr_next;
         dq_out_reg    <= dq_out_next;
         dq_oe_reg     <= dq_oe_next;
         we_n_reg      <= we_n_next;
         oe_n_reg      <= oe_n_next;
      end
   end

   // Load data capture at the end of each half's wait window; stores leave
   // the last loaded value untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data_reg <= '0;
      end else if (!is_store_reg && cnt_last) begin
         if (state_reg == ST_LOW) begin
            read_data_reg[15:0] <= SRAM_DQ_in;
         end else if (state_reg == ST_HIGH) begin
            read_data_reg[31:16] <= SRAM_DQ_in;
         end
      end
   end

   assign ready       = ~req | (state_reg == ST_DONE);
   assign read_data   = read_data_reg;
   assign SRAM_ADDR   = sram_addr_reg;
   assign SRAM_DQ_out = dq_out_reg;
   assign SRAM_DQ_oe  = dq_oe_reg;
   assign SRAM_WE_N   = we_n_reg;
   assign SRAM_OE_N   = oe_n_reg;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: a driver issues loads/stores and
// pushes the expected outcome (from a word-level memory model) into a queue;
// a monitor checks the SRAM bus every cycle and pops/compares on completion.
module tb_mem_sram_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MEM_R_EN = 1'b0;
   logic        MEM_W_EN = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_out;
   logic        SRAM_DQ_oe;
   logic [15:0] SRAM_DQ_in;
   logic        SRAM_WE_N;
   logic        SRAM_OE_N;

   mem_sram_ctrl #(.WAIT_CYCLES(W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .MEM_R_EN   (MEM_R_EN),
      .MEM_W_EN   (MEM_W_EN),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .SRAM_ADDR  (SRAM_ADDR),
      .SRAM_DQ_out(SRAM_DQ_out),
      .SRAM_DQ_oe (SRAM_DQ_oe),
      .SRAM_DQ_in (SRAM_DQ_in),
      .SRAM_WE_N  (SRAM_WE_N),
      .SRAM_OE_N  (SRAM_OE_N)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM device model (small window of the address space).
   logic [15:0] sram_mem [0:1023] = '{default: 16'h0000};
   always @(posedge clk) begin
      if (!SRAM_WE_N) sram_mem[SRAM_ADDR[9:0]] <= SRAM_DQ_out;
   end
   assign SRAM_DQ_in = SRAM_OE_N ? 16'h0000 : sram_mem[SRAM_ADDR[9:0]];

   typedef struct {
      logic        is_load;
      logic [16:0] word;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [int];
   logic [31:0] last_read = '0;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_val);
      checks++;
      if (act !== req_val) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req_val);
      end
   endtask

   // Monitor: per-cycle bus checks and completion scoreboard.
   task automatic monitor();
      int   cyc_cnt = 0;
      exp_t e;
      logic half;
      logic [63:0] act_v, exp_v;
      forever begin
         @(negedge clk);
         if (rst) begin
            cyc_cnt   = 0;
            last_read = '0;
         end else if (MEM_R_EN | MEM_W_EN) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_has_entry", 64'd0, 64'd1);
            end else begin
               e = exp_q[0];
               if (ready) begin
                  chk("latency", 64'(cyc_cnt), 64'(2*W+1));
                  chk("done_strobes", {61'd0, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 64'b110);
                  if (e.is_load) begin
                     chk("load_data", 64'(read_data), 64'(e.data));
                     last_read = e.data;
                  end else begin
                     chk("store_keeps_read_data", 64'(read_data), 64'(last_read));
                     chk("sram_halves", {32'd0, sram_mem[{e.word[8:0], 1'b1}], sram_mem[{e.word[8:0], 1'b0}]},
                         64'(e.data));
                  end
                  $display("txn %s word=%05h data=%08h read_data=%08h cycles=%0d",
                           e.is_load ? "load " : "store", e.word, e.data, read_data, cyc_cnt + 1);
                  void'(exp_q.pop_front());
                  cyc_cnt = 0;
               end else begin
                  if (cyc_cnt >= 1 && cyc_cnt <= 2*W) begin
                     half  = (cyc_cnt > W);
                     act_v = {27'd0, SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe,
                              e.is_load ? 16'h0 : SRAM_DQ_out};
                     exp_v = {27'd0, e.word, half, e.is_load, ~e.is_load, ~e.is_load,
                              e.is_load ? 16'h0 : (half ? e.data[31:16] : e.data[15:0])};
                     chk("access_bus", act_v, exp_v);
                     chk("no_bus_contention", {63'd0, SRAM_DQ_oe & ~SRAM_OE_N}, 64'd0);
                  end else if (cyc_cnt == 0) begin
                     chk("accept_strobes", {61'd0, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 64'b110);
                  end
                  cyc_cnt++;
               end
            end
         end else begin
            cyc_cnt = 0;
            chk("idle_ready_strobes", {60'd0, ready, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 64'b1110);
         end
      end
   endtask

   // Present a request, record its expected result, wait for completion.
   task automatic issue(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      int   waited = 0;
      MEM_R_EN   = r;
      MEM_W_EN   = w;
      address    = addr;
      write_data = data;
      e.is_load  = r & ~w;
      e.word     = addr[18:2];
      if (e.is_load) begin
         e.data = ref_mem.exists(int'(e.word)) ? ref_mem[int'(e.word)] : 32'h0;
      end else begin
         e.data = data;
         ref_mem[int'(e.word)] = data;
      end
      exp_q.push_back(e);
      do begin
         @(negedge clk);
         waited++;
      end while (!ready && waited < 40);
      chk("ready_within_bound", {63'd0, ready}, 64'd1);
      if (!ready) exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr(input int word);
      logic [31:0] a;
      a = $urandom;
      a[18:2] = 17'(word);
      return a;
   endfunction

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_read_data", 64'(read_data), 64'd0);
      chk("rst_sram_addr", 64'(SRAM_ADDR), 64'd0);
      chk("rst_dq_out", 64'(SRAM_DQ_out), 64'd0);
      chk("rst_ready_strobes", {60'd0, ready, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 64'b1110);
      @(negedge clk);
      #1 rst = 1'b0;
      fork
         monitor();
      join_none
      @(posedge clk);
      #1;

      // Directed: store then load of the documented example word.
      issue(1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF);
      chk("sram_0x202", 64'(sram_mem[10'h202]), 64'h0000_BEEF);
      chk("sram_0x203", 64'(sram_mem[10'h203]), 64'h0000_DEAD);
      idle(2);
      issue(1'b1, 1'b0, 32'h0000_0404, 32'h0);
      // Both enables: behaves as a store.
      idle(1);
      issue(1'b1, 1'b1, rand_addr(7), 32'h1234_5678);
      // Back-to-back load then store.
      issue(1'b1, 1'b0, rand_addr(7), 32'h0);
      issue(1'b0, 1'b1, rand_addr(3), $urandom);
      // Ten quiet cycles.
      idle(10);

      // Reset during the HIGH half of a store.
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b1;
      address    = rand_addr(100);
      write_data = $urandom;
      begin
         exp_t e;
         e.is_load = 1'b0;
         e.word    = 17'd100;
         e.data    = write_data;
         exp_q.push_back(e);
      end
      repeat (W + 1) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_store", {29'd0, read_data, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 64'b110);
      exp_q.delete();
      MEM_W_EN = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("post_rst_ready", {63'd0, ready}, 64'd1);
      @(posedge clk);
      #1;

      // Randomized traffic over a small word pool.
      for (int i = 0; i < 40; i++) begin
         int sel;
         int gap;
         sel = $urandom_range(0, 3);
         gap = $urandom_range(0, 2);
         case (sel)
            0, 3: issue(1'b1, 1'b0, rand_addr($urandom_range(0, 31)), $urandom);
            1:    issue(1'b0, 1'b1, rand_addr($urandom_range(0, 31)), $urandom);
            default: issue(1'b1, 1'b1, rand_addr($urandom_range(0, 31)), $urandom);
         endcase
         if (gap > 0) idle(gap);
      end
      idle(3);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
